sync_merge3_mmu: RTL
====================

# sync_merge3_mmu

Clocked 3-to-1 merge for the MMU drive/free token handshake: the converging counterpart of the 3-way selector fork. Up to three upstream sources each hand one token at a time to the block via single-cycle drive pulses. The block serialises them with a round-robin arbiter onto a single downstream drive/free channel. It reports which source owns the forwarded token and returns the downstream free pulse to that source only.

## Interface
- NUM_PORTS, 3, number of upstream sources; fixed at 3, other values unsupported.

- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- i_drive0  in  1  source 0 token pulse (one cycle).
- o_free0  out  1  source 0 release pulse (one cycle).
- i_drive1  in  1  source 1 token pulse.
- o_free1  out  1  source 1 release pulse.
- i_drive2  in  1  source 2 token pulse.
- o_free2  out  1  source 2 release pulse.
- o_driveNext  out  1  downstream token pulse (one cycle).
- i_freeNext  in  1  downstream release pulse (one cycle).
- o_select  out  NUM_PORTS  one-hot owner of the in-flight token; zero when idle.
- o_busy  out  1  token in flight downstream.
- o_err  out  1  sticky protocol-violation flag.

## Operation
- State: pending[2:0], rr_last[1:0] (last granted index), grant[2:0], FSM {IDLE, BUSY}, err.
- pending[K] set by i_driveK. Cleared when o_freeK is issued.
- IDLE:
  - Candidates are pending | {i_drive2,i_drive1,i_drive0}.
  - If any candidate exists, pick the first in order rr_last+1, rr_last+2, rr_last (mod 3).
  - Register o_driveNext=1 for one cycle, o_select=onehot(K), o_busy=1, rr_last=K, and go to BUSY.
- BUSY:
  - o_select and o_busy held.
  - On i_freeNext=1: register o_freeK=1 (K = granted index) for one cycle, clear pending[K], set o_select=0, o_busy=0, and go to IDLE.
- Drives arriving while BUSY are latched in pending and arbitrated on return to IDLE.
- All outputs are registered. No combinational path from any input to any output.
- Violations set err; err clears only on rst:
  - i_driveK while pending[K]=1. The duplicate is dropped.
  - i_freeNext while IDLE. The pulse is ignored, with no o_free generated.
- Reset values:
  - o_free0..2=0, o_driveNext=0, o_select=0, o_busy=0, o_err=0.
  - pending=0, FSM=IDLE.
  - rr_last=2, so the first priority order is 0,1,2.

## Timing
- Drive-to-forward latency, IDLE with no contention: i_driveK at cycle t gives o_driveNext=1 and o_select=onehot(K) at t+1.
- i_freeNext is accepted from the first cycle o_driveNext is high, including that same cycle.
- Free return latency: i_freeNext at cycle t gives o_freeK=1 at t+1, o_busy=0 at t+1.
- Back-to-back turnaround: if another candidate is pending, the next o_driveNext is at t+2. Minimum token period is 2 cycles.
- Simultaneous events:
  - i_driveK in the same cycle as i_freeNext for a different source: the drive is latched and the free is returned normally.
  - i_driveK in the same cycle that o_freeK is being issued: legal. The pending clear and set resolve to set (set wins), and no err is raised.
- Simultaneous drives on multiple sources in IDLE: one is granted, the rest stay pending.
- Fairness: with all three continuously pending, grants rotate 0,1,2,0…
- Reset mid-operation:
  - rst asserted in any cycle clears everything at the next edge. In-flight and pending tokens are discarded and no o_free is issued for them.
  - Inputs during the rst cycle are ignored.

## Test plan
- Single token: pulse i_drive1 at cycle 5 -> o_driveNext=1 and o_select=3'b010 at cycle 6. Pulse i_freeNext at 9 -> o_free1=1 at 10, o_select=0 and o_busy=0 at 10. No other o_free.
- Contention and round-robin: pulse i_drive0/1/2 together at cycle 3 and answer each o_driveNext with i_freeNext the same cycle -> grants 0,1,2 at cycles 4, 6, 8. o_free0/1/2 at cycles 5, 7, 9.
- Rotation resume: after a grant to source 2, pulse i_drive0 and i_drive1 together -> source 0 granted first. After a grant to source 0, the same stimulus -> source 1 granted first.
- Drives while BUSY: source 0 in flight, pulse i_drive2 at cycle 7 and i_freeNext at 10 -> o_free0 at 11 and o_driveNext with o_select=3'b100 at 12.
- Violations: i_drive0 twice before o_free0 -> o_err=1 next cycle, only one o_driveNext for source 0. i_freeNext in IDLE -> o_err=1 and no o_free pulse. o_err stays high until rst.
- Reset mid-flight: assert rst during BUSY with sources 1 and 2 pending -> next cycle all outputs 0 and pending cleared. A subsequent i_freeNext produces no o_free and sets o_err. Next i_drive1 forwards at +1 cycle.

Source files
------------

// File: rtl/sync_merge3_mmu_if.sv
// Purpose : bundles the three upstream drive/free pairs, the downstream drive/free pair
//           and the status outputs of the 3-to-1 token merge.
// Latency : none, wires only.
// Backpressure: none here. Sources wait for their own free pulse before driving again.
// Ports   : i_drive0..2/o_free0..2 (upstream), o_driveNext/i_freeNext (downstream),
//           o_select (one-hot owner), o_busy, o_err.
//           Modport master is the environment side. Modport slave is the merge block.
interface sync_merge3_mmu_if #(
  parameter int NUM_PORTS = 3
);
  logic                 i_drive0;
  logic                 i_drive1;
  logic                 i_drive2;
  logic                 o_free0;
  logic                 o_free1;
  logic                 o_free2;
  logic                 o_driveNext;
  logic                 i_freeNext;
  logic [NUM_PORTS-1:0] o_select;
  logic                 o_busy;
  logic                 o_err;

  modport master (
    output i_drive0, i_drive1, i_drive2, i_freeNext,
    input  o_free0, o_free1, o_free2, o_driveNext, o_select, o_busy, o_err
  );

  modport slave (
    input  i_drive0, i_drive1, i_drive2, i_freeNext,
    output o_free0, o_free1, o_free2, o_driveNext, o_select, o_busy, o_err
  );
endinterface

// File: rtl/sync_merge3_mmu.sv
// Purpose : round-robin 3-to-1 merge of MMU drive/free tokens onto one downstream channel.
// Latency : drive to o_driveNext is 1 cycle. i_freeNext to o_freeK is 1 cycle. Token period is at least 2 cycles.
// Backpressure: one token in flight at a time. Drives that arrive while busy wait in pending.
// Ports   : clk, rst (sync active-high), bus (slave modport: upstream/downstream drive-free pairs,
//           o_select one-hot owner, o_busy, o_err sticky protocol violation).
module sync_merge3_mmu (
  input  logic              clk,
  input  logic              rst,
  sync_merge3_mmu_if.slave  bus
);
  localparam int NUM_PORTS = 3;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t               state_q, state_d;
  logic [NUM_PORTS-1:0] pending_q, pending_d;
  logic [NUM_PORTS-1:0] select_q, select_d;
  logic [NUM_PORTS-1:0] free_q, free_d;
  logic [1:0]           rr_last_q, rr_last_d;
  logic                 drive_next_q, drive_next_d;
  logic                 busy_q, busy_d;
  logic                 err_q, err_d;

  logic [NUM_PORTS-1:0] drv, dup, cand;
  logic [1:0]           c0, c1, c2, pick;
  logic                 pick_vld;

  function automatic logic [1:0] nxt(input logic [1:0] i);
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  function automatic logic [NUM_PORTS-1:0] oh(input logic [1:0] i);
    case (i)
      2'd0:    return 3'b001;
      2'd1:    return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  assign drv  = {bus.i_drive2, bus.i_drive1, bus.i_drive0};
  // A drive on a source that already holds a pending token is a duplicate and gets dropped.
  assign dup  = drv & pending_q;
  assign cand = pending_q | drv;

  // Priority order is rr_last+1, rr_last+2, rr_last. The last matching assignment wins,
  // so the highest-priority slot is tested last.
  always_comb begin
    c0       = nxt(rr_last_q);
    c1       = nxt(c0);
    c2       = rr_last_q;
    pick     = rr_last_q;
    pick_vld = |cand;
    if (|(cand & oh(c2))) pick = c2;
    if (|(cand & oh(c1))) pick = c1;
    if (|(cand & oh(c0))) pick = c0;
  end

  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q | drv;
    select_d     = select_q;
    busy_d       = busy_q;
    rr_last_d    = rr_last_q;
    drive_next_d = 1'b0;
    free_d       = '0;
    err_d        = err_q | (|dup);
    case (state_q)
      IDLE: begin
        if (bus.i_freeNext) err_d = 1'b1;
        if (pick_vld) begin
          drive_next_d = 1'b1;
          select_d     = oh(pick);
          busy_d       = 1'b1;
          rr_last_d    = pick;
          state_d      = BUSY;
        end
      end
      BUSY: begin
        if (bus.i_freeNext) begin
          free_d    = select_q;
          // The owner's pending bit clears. A fresh non-duplicate drive in the same cycle still sets its bit.
          pending_d = (pending_q & ~select_q) | (drv & ~pending_q);
          select_d  = '0;
          busy_d    = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      pending_q    <= '0;
      select_q     <= '0;
      free_q       <= '0;
      rr_last_q    <= 2'd2;
      drive_next_q <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      select_q     <= select_d;
      free_q       <= free_d;
      rr_last_q    <= rr_last_d;
      drive_next_q <= drive_next_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
    end
  end

  assign bus.o_free0     = free_q[0];
  assign bus.o_free1     = free_q[1];
  assign bus.o_free2     = free_q[2];
  assign bus.o_driveNext = drive_next_q;
  assign bus.o_select    = select_q;
  assign bus.o_busy      = busy_q;
  assign bus.o_err       = err_q;
endmodule
